// File: rtl/eth_rx_ctrl.sv
// rtl/eth_rx_ctrl.sv - RMII 100 Mb/s receive control: preamble/SFD, byte assembly, field walk, FCS strip and checks
module eth_rx_ctrl #(
    parameter int pMin_Frame    = 64,
    parameter int pMax_Frame    = 1518,
    parameter int pPreamble_Min = 8
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [1:0]  Rxd,
    input  logic        Crs_Dv,
    output logic [3:0]  Rx_Ctrl_FSM_State,
    output logic [7:0]  Rx_Byte,
    output logic        Rx_Byte_Vld,
    output logic        Rx_Sof,
    output logic [15:0] Rx_Len_Type,
    output logic        Frame_Done,
    output logic        Frame_Good,
    output logic [3:0]  Rx_Err,
    output logic [10:0] Rx_Len
);

    // Encoding shared with the TX control FSM; codes 2 (SFD) and 7 (PAD) are TX-only.
    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        PREAMBLE  = 4'd1,
        DEST_ADDR = 4'd3,
        SRC_ADDR  = 4'd4,
        LEN_TYPE  = 4'd5,
        DATA      = 4'd6,
        FCS_CHK   = 4'd8,
        DROP      = 4'd9
    } rx_state_t;

    localparam logic [10:0] MIN_CNT     = 11'(pMin_Frame);
    localparam logic [10:0] MAX_CNT     = 11'(pMax_Frame + 1);
    localparam logic [7:0]  PRE_MIN     = 8'(pPreamble_Min);
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

    rx_state_t   state;
    rx_state_t   state_nxt;
    logic        armed;
    logic [7:0]  pre_cnt;
    logic [1:0]  dibit_cnt;
    logic [5:0]  byte_sr;
    logic [10:0] byte_cnt;
    logic [31:0] crc;
    logic [7:0]  len_hi;
    logic [7:0]  dline [4];
    logic [2:0]  fill;
    logic        sof_pend;
    logic        too_long;

    logic        in_frame;
    logic        take;
    logic        byte_done;
    logic        hit_max;
    logic        sfd_ok;
    logic [7:0]  new_byte;
    logic [10:0] cnt_inc;
    logic [3:0]  err_vec;

    // Reflected CRC-32, two bits per clock, Rxd[0] is the earlier bit on the wire.
    function automatic logic [31:0] crc_dibit(input logic [31:0] c, input logic [1:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 2; i++) begin
            if (r[0] ^ d[i])
                r = (r >> 1) ^ 32'hEDB88320;
            else
                r = r >> 1;
        end
        return r;
    endfunction

    assign in_frame  = (state == DEST_ADDR) || (state == SRC_ADDR) ||
                       (state == LEN_TYPE)  || (state == DATA);
    assign take      = in_frame && Crs_Dv;
    assign byte_done = take && (dibit_cnt == 2'd3);
    assign new_byte  = {Rxd, byte_sr};
    assign cnt_inc   = (byte_cnt == 11'h7FF) ? byte_cnt : byte_cnt + 11'd1;
    assign hit_max   = byte_done && (cnt_inc == MAX_CNT);
    assign sfd_ok    = (state == PREAMBLE) && Crs_Dv && (Rxd == 2'b11) && (pre_cnt >= PRE_MIN);

    always_ff @(posedge Clk) begin
        if (Rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (armed && Crs_Dv && (Rxd == 2'b01))
                    state_nxt = PREAMBLE;
            end
            PREAMBLE: begin
                if (!Crs_Dv)
                    state_nxt = IDLE;
                else if (sfd_ok)
                    state_nxt = DEST_ADDR;
                else if (Rxd != 2'b01)
                    state_nxt = DROP;
            end
            DEST_ADDR, SRC_ADDR, LEN_TYPE, DATA: begin
                if (!Crs_Dv || hit_max)
                    state_nxt = FCS_CHK;
                else if (byte_done) begin
                    if (cnt_inc == 11'd6)
                        state_nxt = SRC_ADDR;
                    else if (cnt_inc == 11'd12)
                        state_nxt = LEN_TYPE;
                    else if (cnt_inc == 11'd14)
                        state_nxt = DATA;
                end
            end
            FCS_CHK: begin
                state_nxt = too_long ? DROP : IDLE;
            end
            DROP: begin
                if (!Crs_Dv)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            Rx_Byte     <= 8'd0;
            Rx_Byte_Vld <= 1'b0;
            Rx_Sof      <= 1'b0;
            Rx_Len_Type <= 16'd0;
            armed       <= 1'b0;
            pre_cnt     <= 8'd0;
            dibit_cnt   <= 2'd0;
            byte_sr     <= 6'd0;
            byte_cnt    <= 11'd0;
            crc         <= 32'd0;
            len_hi      <= 8'd0;
            fill        <= 3'd0;
            sof_pend    <= 1'b0;
            too_long    <= 1'b0;
            for (int i = 0; i < 4; i++)
                dline[i] <= 8'd0;
        end else begin
            Rx_Byte_Vld <= 1'b0;
            Rx_Sof      <= 1'b0;

            if (((state == IDLE) && !Crs_Dv) || (state == FCS_CHK))
                armed <= 1'b1;

            if (state == IDLE)
                pre_cnt <= 8'd1;
            else if ((state == PREAMBLE) && Crs_Dv && (Rxd == 2'b01) && (pre_cnt != 8'hFF))
                pre_cnt <= pre_cnt + 8'd1;

            if (sfd_ok) begin
                dibit_cnt <= 2'd0;
                byte_cnt  <= 11'd0;
                crc       <= 32'hFFFFFFFF;
                fill      <= 3'd0;
                sof_pend  <= 1'b1;
                too_long  <= 1'b0;
            end

            if (take) begin
                crc       <= crc_dibit(crc, Rxd);
                dibit_cnt <= dibit_cnt + 2'd1;
                case (dibit_cnt)
                    2'd0:    byte_sr[1:0] <= Rxd;
                    2'd1:    byte_sr[3:2] <= Rxd;
                    2'd2:    byte_sr[5:4] <= Rxd;
                    default: ;
                endcase
            end

            if (byte_done) begin
                byte_cnt <= cnt_inc;
                if (hit_max)
                    too_long <= 1'b1;
                if (cnt_inc == 11'd13)
                    len_hi <= new_byte;
                if (cnt_inc == 11'd14)
                    Rx_Len_Type <= {len_hi, new_byte};
                // The last four bytes held here at frame end are the FCS and never leave.
                dline[0] <= dline[1];
                dline[1] <= dline[2];
                dline[2] <= dline[3];
                dline[3] <= new_byte;
                if (fill == 3'd4) begin
                    Rx_Byte     <= dline[0];
                    Rx_Byte_Vld <= 1'b1;
                    Rx_Sof      <= sof_pend;
                    sof_pend    <= 1'b0;
                end else begin
                    fill <= fill + 3'd1;
                end
            end
        end
    end

    always_comb begin
        err_vec    = too_long ? 4'b0100
                              : {(dibit_cnt != 2'd0), 1'b0, (byte_cnt < MIN_CNT), (crc != CRC_RESIDUE)};
        Frame_Done = (state == FCS_CHK);
        Rx_Err     = Frame_Done ? err_vec : 4'd0;
        Frame_Good = Frame_Done && (err_vec == 4'd0);
        Rx_Len     = (Frame_Done && (byte_cnt >= 11'd4)) ? byte_cnt - 11'd4 : 11'd0;
    end

    assign Rx_Ctrl_FSM_State = state;

endmodule

// File: tb/tb_eth_rx_ctrl.sv
// tb/tb_eth_rx_ctrl.sv - randomized self-checking bench for eth_rx_ctrl against a frame-level model
module tb_eth_rx_ctrl;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [1:0]  Rxd;
    logic        Crs_Dv;
    logic [3:0]  Rx_Ctrl_FSM_State;
    logic [7:0]  Rx_Byte;
    logic        Rx_Byte_Vld;
    logic        Rx_Sof;
    logic [15:0] Rx_Len_Type;
    logic        Frame_Done;
    logic        Frame_Good;
    logic [3:0]  Rx_Err;
    logic [10:0] Rx_Len;

    always #10 Clk = ~Clk;

    eth_rx_ctrl dut (
        .Clk               (Clk),
        .Rst               (Rst),
        .Rxd               (Rxd),
        .Crs_Dv            (Crs_Dv),
        .Rx_Ctrl_FSM_State (Rx_Ctrl_FSM_State),
        .Rx_Byte           (Rx_Byte),
        .Rx_Byte_Vld       (Rx_Byte_Vld),
        .Rx_Sof            (Rx_Sof),
        .Rx_Len_Type       (Rx_Len_Type),
        .Frame_Done        (Frame_Done),
        .Frame_Good        (Frame_Good),
        .Rx_Err            (Rx_Err),
        .Rx_Len            (Rx_Len)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    logic [8:0]  got_q [$];
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          gap_bad  = 0;
    int          last_vld = -100;
    logic [3:0]  d_err;
    logic        d_good;
    logic [10:0] d_len;
    logic [15:0] d_lt;

    always @(negedge Clk) begin
        if (Rx_Byte_Vld) begin
            got_q.push_back({Rx_Sof, Rx_Byte});
            if (cyc - last_vld < 4)
                gap_bad++;
            last_vld = cyc;
        end
        if (Frame_Done) begin
            done_cnt++;
            done_cyc = cyc;
            d_err    = Rx_Err;
            d_good   = Frame_Good;
            d_len    = Rx_Len;
            d_lt     = Rx_Len_Type;
        end
    end

    logic [7:0] frm [$];

    function automatic logic [31:0] crc32_of(input int n);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {24'd0, frm[i]};
            for (int b = 0; b < 8; b++)
                c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    task automatic build_frame(input int n, input logic [15:0] len_type);
        logic [31:0] fcs;
        frm.delete();
        for (int i = 0; i < n - 4; i++) begin
            if (i == 12)
                frm.push_back(len_type[15:8]);
            else if (i == 13)
                frm.push_back(len_type[7:0]);
            else
                frm.push_back(8'($urandom));
        end
        fcs = crc32_of(n - 4);
        for (int k = 0; k < 4; k++)
            frm.push_back(fcs[8*k +: 8]);
    endtask

    task automatic send_dibit(input logic [1:0] d, input logic dv);
        @(negedge Clk);
        Rxd    = d;
        Crs_Dv = dv;
    endtask

    task automatic run_frame(input string nm, input int pre, input int extra,
                             input bit corrupt, input int rst_byte);
        int         n;
        int         last_cyc;
        int         drop_cyc;
        int         exp_strobes;
        int         exp_st;
        int         nbad;
        int         sof_bad;
        bit         pre_short;
        bit         tl;
        logic [7:0] b;
        logic [3:0] exp_err;
        logic [3:0] st_bd;
        n        = frm.size();
        last_cyc = 0;
        repeat (3) send_dibit(2'b00, 1'b0);
        got_q.delete();
        done_cnt = 0;
        gap_bad  = 0;
        last_vld = -100;
        for (int i = 0; i < pre; i++)
            send_dibit(2'b01, 1'b1);
        send_dibit(2'b11, 1'b1);
        for (int i = 0; i < n; i++) begin
            if (i == rst_byte) begin
                @(negedge Clk);
                Rst = 1'b1;
                @(negedge Clk);
                Rst = 1'b0;
                chk({nm, ":rst_state"}, 32'(Rx_Ctrl_FSM_State), 32'd0);
                chk({nm, ":rst_vld"}, 32'(Rx_Byte_Vld), 32'd0);
                chk({nm, ":rst_byte"}, 32'(Rx_Byte), 32'd0);
                chk({nm, ":rst_lt"}, 32'(Rx_Len_Type), 32'd0);
                got_q.delete();
            end
            b = frm[i];
            for (int k = 0; k < 4; k++)
                send_dibit(b[2*k +: 2], 1'b1);
            if (i == 1518)
                last_cyc = cyc;
        end
        for (int e = 0; e < extra; e++)
            send_dibit(2'($urandom_range(0, 3)), 1'b1);
        @(negedge Clk);
        st_bd    = Rx_Ctrl_FSM_State;
        Rxd      = 2'b00;
        Crs_Dv   = 1'b0;
        drop_cyc = cyc;
        repeat (6) send_dibit(2'b00, 1'b0);

        pre_short = (pre < 8);
        tl        = !pre_short && (rst_byte < 0) && (n >= 1519);
        if (pre_short || (rst_byte >= 0))
            exp_strobes = 0;
        else if (tl)
            exp_strobes = 1515;
        else
            exp_strobes = n - 4;
        if (rst_byte >= 0)
            exp_st = 0;
        else if (pre_short || tl)
            exp_st = 9;
        else
            exp_st = (n < 6) ? 3 : (n < 12) ? 4 : (n < 14) ? 5 : 6;

        chk({nm, ":state_at_drop"}, 32'(st_bd), 32'(exp_st));
        chk({nm, ":state_end"}, 32'(Rx_Ctrl_FSM_State), 32'd0);
        chk({nm, ":done_cnt"}, 32'(done_cnt), (pre_short || (rst_byte >= 0)) ? 32'd0 : 32'd1);
        chk({nm, ":strobes"}, 32'(got_q.size()), 32'(exp_strobes));
        chk({nm, ":gap"}, 32'(gap_bad), 32'd0);

        nbad    = 0;
        sof_bad = 0;
        for (int i = 0; i < got_q.size() && i < n; i++) begin
            if (got_q[i][7:0] !== frm[i])
                nbad++;
            if (got_q[i][8] !== (i == 0))
                sof_bad++;
        end
        chk({nm, ":bytes"}, 32'(nbad), 32'd0);
        chk({nm, ":sof"}, 32'(sof_bad), 32'd0);

        if (!pre_short && (rst_byte < 0) && (done_cnt > 0)) begin
            if (tl)
                exp_err = 4'b0100;
            else
                exp_err = {(extra % 4) != 0, 1'b0, n < 64, corrupt || (extra > 0)};
            chk({nm, ":err"}, 32'(d_err), 32'(exp_err));
            chk({nm, ":good"}, 32'(d_good), 32'(exp_err == 4'd0));
            chk({nm, ":len"}, 32'(d_len), tl ? 32'd1515 : 32'(n - 4));
            chk({nm, ":len_type"}, 32'(d_lt), {16'd0, frm[12], frm[13]});
            chk({nm, ":done_cyc"}, 32'(done_cyc), tl ? 32'(last_cyc + 1) : 32'(drop_cyc + 1));
        end
    endtask

    initial begin
        int n;
        int idx;
        int pre;
        int extra;
        bit corrupt;

        Rst    = 1'b1;
        Crs_Dv = 1'b0;
        Rxd    = 2'b00;
        repeat (3) @(negedge Clk);
        chk("reset:state", 32'(Rx_Ctrl_FSM_State), 32'd0);
        chk("reset:vld", 32'(Rx_Byte_Vld), 32'd0);
        chk("reset:sof", 32'(Rx_Sof), 32'd0);
        chk("reset:byte", 32'(Rx_Byte), 32'd0);
        chk("reset:lt", 32'(Rx_Len_Type), 32'd0);
        chk("reset:done", 32'(Frame_Done), 32'd0);
        chk("reset:good", 32'(Frame_Good), 32'd0);
        chk("reset:err", 32'(Rx_Err), 32'd0);
        chk("reset:len", 32'(Rx_Len), 32'd0);
        Rst = 1'b0;

        build_frame(64, 16'h0800);
        run_frame("good64", 31, 0, 1'b0, -1);

        frm[60] = frm[60] ^ 8'h01;
        run_frame("fcs_flip", 31, 0, 1'b1, -1);

        build_frame(63, 16'h0800);
        run_frame("runt63", 31, 0, 1'b0, -1);
        run_frame("runt63_dibit", 31, 1, 1'b0, -1);

        build_frame(1525, 16'h86DD);
        run_frame("too_long", 31, 0, 1'b0, -1);

        build_frame(80, 16'h0806);
        run_frame("short_pre", 3, 0, 1'b0, -1);
        run_frame("after_short", 31, 0, 1'b0, -1);

        build_frame(100, 16'h0800);
        run_frame("rst_mid", 31, 0, 1'b0, 30);
        build_frame(70, 16'h0800);
        run_frame("after_rst", 31, 0, 1'b0, -1);

        build_frame(64, 16'h0800);
        run_frame("pre_min", 8, 0, 1'b0, -1);
        run_frame("pre_min_m1", 7, 0, 1'b0, -1);

        for (int r = 0; r < 6; r++) begin
            n       = $urandom_range(64, 200);
            pre     = $urandom_range(6, 31);
            extra   = $urandom_range(0, 3);
            corrupt = 1'($urandom_range(0, 1));
            build_frame(n, 16'($urandom));
            if (corrupt) begin
                idx      = $urandom_range(0, n - 1);
                frm[idx] = frm[idx] ^ (8'd1 << $urandom_range(0, 7));
            end
            run_frame($sformatf("rand%0d", r), pre, extra, corrupt, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/eth_rx_ctrl.md
Name: eth_rx_ctrl

Overview:
RMII receive control for the 100 Mb/s path. It receives 2-bit dibits from the PHY, detects preamble and SFD, assembles bytes LSB-first, walks the frame fields and forwards header and payload bytes. FCS bytes are stripped, and CRC-32, length and alignment are checked. It sits between the RMII pins and the RX FIFO writer, mirroring the TX control FSM and sharing its state encoding.

Parameters:
pMin_Frame, 64, minimum legal byte count from DEST_ADDR through FCS inclusive
pMax_Frame, 1518, maximum legal byte count from DEST_ADDR through FCS inclusive
pPreamble_Min, 8, minimum count of consecutive 01 dibits required before the SFD 11 dibit

Ports:
Clk  in  1  50 MHz RMII reference clock
Rst  in  1  synchronous reset, active-high
Rxd  in  2  RMII receive dibit, LSB-first within each byte
Crs_Dv  in  1  carrier/data valid; PHY is configured for DV-only mode (no toggling)
Rx_Ctrl_FSM_State  out  4  current state
Rx_Byte  out  8  forwarded byte
Rx_Byte_Vld  out  1  one-cycle strobe for Rx_Byte
Rx_Sof  out  1  high together with the first Rx_Byte_Vld of a frame
Rx_Len_Type  out  16  captured length/type field; first received byte is the MSB
Frame_Done  out  1  one-cycle end-of-frame strobe
Frame_Good  out  1  valid while Frame_Done is high
Rx_Err  out  4  valid while Frame_Done is high: [0] CRC, [1] runt, [2] too long, [3] misaligned
Rx_Len  out  11  number of bytes forwarded (FCS excluded); valid while Frame_Done is high

Behaviour:
- Reset: all outputs are 0 and the state is IDLE. The arm flag is cleared, so a new frame is accepted only after Crs_Dv has been sampled low at least once. No Frame_Done is issued for a frame interrupted by reset.
- State encoding: IDLE=0, PREAMBLE=1, DEST_ADDR=3, SRC_ADDR=4, LEN_TYPE=5, DATA=6, FCS_CHK=8, DROP=9. Codes 2 (SFD) and 7 (PAD) are TX-only and never entered.
- IDLE:
  - Crs_Dv=0 sets the arm flag.
  - Armed, Crs_Dv=1 and Rxd=01 -> PREAMBLE, preamble count=1.
  - Rxd=00 with Crs_Dv=1: stay in IDLE.
- PREAMBLE:
  - Rxd=01: count increments, saturating.
  - Rxd=11 with count>=pPreamble_Min -> DEST_ADDR; dibit, byte and CRC counters cleared; CRC register set to 0xFFFFFFFF.
  - Rxd=11 with count<pPreamble_Min, or Rxd=00/10 -> DROP.
  - Crs_Dv=0 -> IDLE.
- Byte assembly:
  - Each Crs_Dv=1 dibit is shifted in at bit position 2*k, k=0..3; the byte completes on the 4th dibit.
  - The CRC is updated on every dibit: reflected polynomial 0xEDB88320, 2 bits per clock.
- Field progression by byte count after SFD:
  - DEST_ADDR: bytes 0-5
  - SRC_ADDR: bytes 6-11
  - LEN_TYPE: bytes 12-13; Rx_Len_Type updates when byte 13 completes
  - DATA: from byte 14 onward
- Forwarding:
  - Completed bytes enter a 4-deep delay line.
  - When a byte completes and the line already holds 4 bytes, the oldest byte is driven on Rx_Byte with Rx_Byte_Vld=1 on the next cycle.
  - Rx_Sof accompanies the first such strobe.
  - Strobes are never closer than 4 cycles apart.
  - At frame end the 4 bytes left in the line are the FCS and are discarded.
- End of frame:
  - Crs_Dv sampled 0 in DEST_ADDR..DATA -> FCS_CHK.
  - In FCS_CHK (one cycle): Frame_Done=1, Rx_Len, Rx_Err and Frame_Good driven; next state IDLE with the arm flag set.
  - Frame_Done therefore occurs 1 cycle after the first low Crs_Dv sample.
- Error checks:
  - Rx_Err[0]: CRC register != 0xDEBB20E3.
  - Rx_Err[1]: byte count < pMin_Frame.
  - Rx_Err[3]: dibit count not a multiple of 4; the partial byte is discarded and not forwarded.
  - Frame_Good = (Rx_Err == 0).
- Too long:
  - When byte count reaches pMax_Frame+1, FCS_CHK is entered immediately with Rx_Err[2]=1 and Frame_Good=0, then DROP.
  - No further strobes are issued.
- DROP: outputs idle; -> IDLE on Crs_Dv=0.
- Counter widths: byte count is 11 bits and saturates. Rx_Len = byte count − 4, floored at 0.

Test Plan:
1. 7×0x55+0xD5 preamble/SFD, 64-byte frame (type 0x0800, 46-byte payload, correct FCS) -> 60 Rx_Byte_Vld strobes, the first with Rx_Sof and value equal to dest byte 0; Rx_Len_Type=0x0800; Frame_Done 1 cycle after Crs_Dv falls with Frame_Good=1, Rx_Err=0, Rx_Len=60.
2. Same frame with FCS bit 0 flipped -> Frame_Good=0, Rx_Err=4'b0001, Rx_Len=60.
3. 63-byte frame with correct CRC -> Rx_Err=4'b0010. Same frame plus one extra dibit -> Rx_Err bit3 set, extra dibit not forwarded.
4. 1519-byte stream -> Frame_Done with Rx_Err=4'b0100 when byte 1519 completes, state=9, no strobes until Crs_Dv is low, then state=0.
5. Preamble of only 3× 01 dibits then 11 -> DROP, no strobes, no Frame_Done. A following good frame -> Frame_Good=1.
6. Rst pulsed mid-DATA while Crs_Dv stays high -> outputs 0, no Frame_Done for the rest of that frame. The next frame, after Crs_Dv goes low, is received with Frame_Good=1.
